uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
Protocol-side responder at the far end of the UART link. It consumes received bytes as a 3-byte command frame (operand A, operand B, opcode), drives the combinational ALU, then hands the 1-byte result to the transmitter and waits for its completion. It sits between rx_uart/tx_uart and the ALU in the top level, replacing the direct rx-to-tx loopback.

Parameters:
NB_DATA, 8, width of UART data bytes, ALU operands and ALU result
NB_OP, 6, ALU opcode width; taken from the low NB_OP bits of the third byte
TIMEOUT_CYCLES, 50000000, clocks allowed between consecutive frame bytes before the partial frame is discarded
NB_TIMEOUT, 26, width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES

Ports:
i_clock  input  1  system clock; single clock domain
i_reset  input  1  synchronous, active-high reset
i_rx_data  input  NB_DATA  byte from rx_uart; valid when i_rx_done_tick=1
i_rx_done_tick  input  1  one-cycle pulse: new byte received
i_tx_done_tick  input  1  one-cycle pulse: tx_uart finished the stop bit
i_alu_result  input  NB_DATA  combinational ALU result for o_alu_a/o_alu_b/o_alu_op
o_alu_a  output  NB_DATA  registered operand A
o_alu_b  output  NB_DATA  registered operand B
o_alu_op  output  NB_OP  registered opcode
o_tx_start  output  1  one-cycle start pulse to tx_uart
o_tx_data  output  NB_DATA  byte to transmit; stable from o_tx_start until i_tx_done_tick
o_busy  output  1  high in any state other than WAIT_A
o_frame_error  output  1  one-cycle pulse when a partial frame is discarded by timeout

Behaviour:
- Reset (synchronous, i_reset=1 at a rising edge) applies in any state, including mid-frame and mid-transmission. The state goes to WAIT_A. All outputs are forced to 0, and the timeout counter is forced to 0.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done_tick, o_alu_a <= i_rx_data, then go to WAIT_B.
- WAIT_B: on i_rx_done_tick, o_alu_b <= i_rx_data, then go to WAIT_OP.
- WAIT_OP: on i_rx_done_tick, o_alu_op <= i_rx_data[NB_OP-1:0], then go to EXEC. Upper byte bits are ignored.
- EXEC: exactly one cycle, to let the ALU settle. o_tx_data <= i_alu_result, then go to SEND.
- SEND: exactly one cycle. o_tx_start=1 during this cycle only, then go to WAIT_TX.
- WAIT_TX: hold o_tx_data. On i_tx_done_tick go to WAIT_A. There is no timeout in this state.
- Latency: o_tx_start rises 2 clocks after the cycle in which the opcode byte's i_rx_done_tick is sampled.
- Timeout counter:
  - Counts only in WAIT_B and WAIT_OP.
  - Clears on every accepted byte and on entry to WAIT_A.
  - When it reaches TIMEOUT_CYCLES-1 with no i_rx_done_tick that cycle: go to WAIT_A, pulse o_frame_error for 1 cycle, counter <= 0. Operand registers keep their stale values.
  - If i_rx_done_tick coincides with the expiry cycle, the byte wins: it is accepted, there is no error, and the FSM advances.
- i_rx_done_tick in EXEC, SEND or WAIT_TX: the byte is dropped silently. No state change, no register update.
- i_tx_done_tick outside WAIT_TX: ignored.
- o_alu_a, o_alu_b and o_alu_op hold their values until overwritten by the next frame; they do not clear after transmission.
- o_busy = (state != WAIT_A), registered alongside the state.
- All arithmetic is unsigned. The counter saturation compare uses NB_TIMEOUT bits.

Test Plan:
1. Frame 8'h05, 8'h03, 8'h20, with the ALU model computing ADD for opcode 6'h20 -> o_alu_a=8'h05, o_alu_b=8'h03, o_alu_op=6'h20; o_tx_start pulses 2 clocks after the third rx tick with o_tx_data=8'h08; after i_tx_done_tick, o_busy=0.
2. Opcode byte 8'hE2 (SUB, upper bits set), A=8'h10, B=8'h01 -> o_alu_op=6'h22, o_tx_data=8'h0F; the upper two byte bits are ignored.
3. TIMEOUT_CYCLES=100; send 8'h07, then nothing for 100 clocks -> one o_frame_error pulse, state WAIT_A, o_busy=0. Next frame 8'h01, 8'h01, 8'h20 -> o_tx_data=8'h02.
4. Second byte's i_rx_done_tick arrives exactly on the expiry cycle -> no o_frame_error, FSM advances to WAIT_OP.
5. Extra i_rx_done_tick (8'hFF) during WAIT_TX, and a spurious i_tx_done_tick in WAIT_A -> o_tx_data and operands unchanged, no state change; the following valid frame is processed normally.
6. Assert i_reset for 1 cycle in WAIT_OP and again in WAIT_TX -> next cycle all outputs are 0, state is WAIT_A, and no o_tx_start is issued for the aborted frame.

Source files
------------

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: assembles a 3-byte command frame (A, B, opcode) from
// rx_uart. It presents the frame to a combinational ALU, then returns the
// 1-byte result through tx_uart and waits for that transmission to finish.
//
// Handshake semantics (one-cycle pulses, no back-pressure):
//   i_rx_done_tick : i_rx_data is valid in this cycle only. It is accepted
//                    in WAIT_A/WAIT_B/WAIT_OP and dropped in any other state.
//   o_tx_start     : one-cycle request. o_tx_data stays stable from this
//                    pulse until i_tx_done_tick is seen in WAIT_TX.
//   i_tx_done_tick : completion from tx_uart. It only has an effect in
//                    WAIT_TX.
//   o_frame_error  : one-cycle pulse when a partial frame is dropped
//                    because the next byte did not arrive in time.
// o_state exposes the FSM encoding for debug and checkers:
//   0 = WAIT_A, 1 = WAIT_B, 2 = WAIT_OP, 3 = EXEC, 4 = SEND, 5 = WAIT_TX.
module uart_alu_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int NB_TIMEOUT     = 26
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done_tick,
  input  logic               i_tx_done_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_frame_error,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  // Last count value before a partial frame is abandoned.
  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_expire;
  logic                  w_in_frame;
  logic [NB_TIMEOUT-1:0] r_timeout_cnt;
  logic [NB_DATA-1:0]    r_alu_a;
  logic [NB_DATA-1:0]    r_alu_b;
  logic [NB_OP-1:0]      r_alu_op;
  logic [NB_DATA-1:0]    r_tx_data;
  logic                  r_tx_start;
  logic                  r_busy;
  logic                  r_frame_error;

  // Timeout only runs while a frame is partially received.
  assign w_in_frame = (r_state == WAIT_B) || (r_state == WAIT_OP);

  // Next-state logic. A byte arriving on the expiry cycle takes priority
  // over the timeout.
  always_comb begin
    w_next_state = r_state;
    w_expire     = 1'b0;
    case (r_state)
      WAIT_A: begin
        if (i_rx_done_tick) w_next_state = WAIT_B;
      end
      WAIT_B: begin
        if (i_rx_done_tick) begin
          w_next_state = WAIT_OP;
        end else if (r_timeout_cnt == TIMEOUT_LAST) begin
          w_next_state = WAIT_A;
          w_expire     = 1'b1;
        end
      end
      WAIT_OP: begin
        if (i_rx_done_tick) begin
          w_next_state = EXEC;
        end else if (r_timeout_cnt == TIMEOUT_LAST) begin
          w_next_state = WAIT_A;
          w_expire     = 1'b1;
        end
      end
      EXEC:    w_next_state = SEND;
      SEND:    w_next_state = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done_tick) w_next_state = WAIT_A;
      end
      default: w_next_state = WAIT_A;
    endcase
  end

  // State register. The control outputs are registered from the next state,
  // so they line up with the state they describe.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= WAIT_A;
      r_busy        <= 1'b0;
      r_tx_start    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_busy        <= (w_next_state != WAIT_A);
      r_tx_start    <= (w_next_state == SEND);
      r_frame_error <= w_expire;
    end
  end

  // Inter-byte timeout counter. It clears on an accepted byte, on expiry
  // and whenever no frame is in progress.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_timeout_cnt <= '0;
    end else if (w_in_frame && !i_rx_done_tick && !w_expire) begin
      r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end else begin
      r_timeout_cnt <= '0;
    end
  end

  // Operand and result capture. Values persist until the next frame
  // overwrites them, including across a timed-out frame.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_tx_data <= '0;
    end else begin
      case (r_state)
        WAIT_A:  if (i_rx_done_tick) r_alu_a  <= i_rx_data;
        WAIT_B:  if (i_rx_done_tick) r_alu_b  <= i_rx_data;
        WAIT_OP: if (i_rx_done_tick) r_alu_op <= i_rx_data[NB_OP-1:0];
        EXEC:    r_tx_data <= i_alu_result;
        default: ;
      endcase
    end
  end

  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_busy        = r_busy;
  assign o_frame_error = r_frame_error;
  assign o_state       = r_state;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: a table of whole frames plus directed
// sequences for the timeout, dropped-tick and reset cases.
module tb_uart_alu_interface;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_tick = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy, frame_error;
  logic [2:0] state;

  int n_checks = 0;
  int n_err    = 0;
  int n_start  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
  } vec_t;
  vec_t vecs[7];

  uart_alu_interface #(
    .NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(TMO), .NB_TIMEOUT(26)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data),
    .i_rx_done_tick(rx_tick), .i_tx_done_tick(tx_done),
    .i_alu_result(alu_result), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_op(alu_op), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_busy(busy), .o_frame_error(frame_error), .o_state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Environment ALU: 20 ADD, 22 SUB, 24 AND, 25 OR, 26 XOR, else 0.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      6'h20: alu_result = alu_a + alu_b;
      6'h22: alu_result = alu_a - alu_b;
      6'h24: alu_result = alu_a & alu_b;
      6'h25: alu_result = alu_a | alu_b;
      6'h26: alu_result = alu_a ^ alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  always @(negedge clk) if (tx_start) n_start++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] d);
    @(posedge clk); #1;
    rx_data = d;
    rx_tick = 1'b1;
    @(posedge clk); #1;
    rx_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    @(negedge clk);
    check({name, "_ops"}, {10'd0, alu_a, alu_b, alu_op}, 32'h0);
    check({name, "_ctl"}, {18'd0, tx_start, tx_data, busy, frame_error, state}, 32'h0);
  endtask

  // Sends a frame and checks capture, start latency and result; ends in WAIT_TX.
  task automatic start_frame(input string name, input vec_t v);
    send_byte(v.a);
    send_byte(v.b);
    send_byte(v.opb);
    @(negedge clk);
    check({name, "_a"}, 32'(alu_a), 32'(v.a));
    check({name, "_b"}, 32'(alu_b), 32'(v.b));
    check({name, "_op"}, 32'(alu_op), 32'(v.exp_op));
    check({name, "_start_early"}, 32'(tx_start), 32'd0);
    @(negedge clk);
    check({name, "_start"}, 32'(tx_start), 32'd1);
    check({name, "_res"}, 32'(tx_data), 32'(v.exp_res));
    @(negedge clk);
    check({name, "_start_once"}, 32'(tx_start), 32'd0);
    check({name, "_waittx"}, {30'd0, busy, (state == 3'd5)}, 32'd3);
    repeat (3) @(negedge clk);
    check({name, "_hold"}, 32'(tx_data), 32'(v.exp_res));
  endtask

  task automatic end_frame(input string name);
    pulse_tx_done();
    @(negedge clk);
    check({name, "_idle"}, {29'd0, busy, state}, 32'd0);
  endtask

  initial begin
    int err_seen;
    int s0;
    vec_t v;
    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vecs[1] = '{8'h10, 8'h01, 8'hE2, 6'h22, 8'h0F};
    vecs[2] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
    vecs[3] = '{8'h00, 8'h01, 8'h22, 6'h22, 8'hFF};
    vecs[4] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
    vecs[5] = '{8'hF0, 8'h3C, 8'h65, 6'h25, 8'hFC};
    vecs[6] = '{8'hA5, 8'hFF, 8'hA6, 6'h26, 8'h5A};

    repeat (3) @(posedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // table-driven frames
    for (int i = 0; i < 7; i++) begin
      start_frame($sformatf("v%0d", i), vecs[i]);
      end_frame($sformatf("v%0d", i));
    end

    // timeout after one byte: 100 idle clocks in WAIT_B
    send_byte(8'h07);
    err_seen = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (frame_error || !busy) err_seen++;
    end
    check("tmo_not_early", 32'(err_seen), 32'd0);
    @(negedge clk);
    check("tmo_err", 32'(frame_error), 32'd1);
    check("tmo_idle", {29'd0, busy, state}, 32'd0);
    check("tmo_stale_a", 32'(alu_a), 32'h07);
    @(negedge clk);
    check("tmo_err_once", 32'(frame_error), 32'd0);
    v = '{8'h01, 8'h01, 8'h20, 6'h20, 8'h02};
    start_frame("after_tmo", v);
    end_frame("after_tmo");

    // second byte exactly on the expiry cycle: byte wins
    send_byte(8'h08);
    repeat (TMO - 2) @(posedge clk);
    send_byte(8'h02);
    @(negedge clk);
    check("edge_no_err", 32'(frame_error), 32'd0);
    check("edge_state", 32'(state), 32'd2);
    check("edge_b", 32'(alu_b), 32'h02);
    send_byte(8'h22);
    repeat (2) @(negedge clk);
    check("edge_res", {23'd0, tx_start, tx_data}, 32'h106);
    end_frame("edge");

    // dropped rx tick in WAIT_TX, spurious tx_done in WAIT_A
    v = '{8'h20, 8'h05, 8'h22, 6'h22, 8'h1B};
    start_frame("drop", v);
    send_byte(8'hFF);
    @(negedge clk);
    check("drop_state", 32'(state), 32'd5);
    check("drop_keep", {2'd0, alu_a, alu_b, alu_op, tx_data}, {2'd0, 8'h20, 8'h05, 6'h22, 8'h1B});
    end_frame("drop");
    s0 = n_start;
    pulse_tx_done();
    @(negedge clk);
    check("spur_done", {29'd0, busy, state}, 32'd0);
    check("spur_keep", {10'd0, alu_a, alu_b, alu_op}, {10'd0, 8'h20, 8'h05, 6'h22});
    check("spur_no_start", 32'(n_start - s0), 32'd0);
    start_frame("post_drop", vecs[0]);
    end_frame("post_drop");

    // reset in WAIT_OP
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    check("pre_rst_state", 32'(state), 32'd2);
    pulse_reset();
    check_all_zero("rst_waitop");
    s0 = n_start;
    repeat (6) @(negedge clk);
    check("rst_waitop_no_start", 32'(n_start - s0), 32'd0);

    // reset in WAIT_TX
    start_frame("pre_rst_tx", vecs[4]);
    pulse_reset();
    check_all_zero("rst_waittx");
    s0 = n_start;
    repeat (6) @(negedge clk);
    check("rst_waittx_no_start", {31'd0, busy} + 32'(n_start - s0), 32'd0);

    start_frame("recover", vecs[1]);
    end_frame("recover");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
